// File: rtl/block_xfer_ctrl.sv
// Instruction control decoder with a block-transfer sequencer.
// Ordinary instructions produce one registered control word. A block
// transfer (mode 11) produces one transfer per edge, one for each set bit of
// the register mask, and raises busy while transfers remain.
module block_xfer_ctrl #(
  parameter int REG_COUNT = 16,
  parameter int ADDR_STEP = 4,
  parameter int OFF_W     = $clog2(REG_COUNT*ADDR_STEP)+1,
  parameter int IDX_W     = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instValid,
  input  logic [1:0]           mode,
  input  logic [3:0]           opcode,
  input  logic                 sIn,
  input  logic [REG_COUNT-1:0] regList,
  input  logic                 upDir,
  input  logic                 freeze,
  input  logic                 flush,
  output logic [3:0]           aluCmd,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 wbEn,
  output logic                 branch,
  output logic                 sOut,
  output logic                 ctrlValid,
  output logic [IDX_W-1:0]     xferReg,
  output logic [OFF_W-1:0]     xferOff,
  output logic                 xferUp,
  output logic                 lastXfer,
  output logic                 busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                 state_q;
  logic [REG_COUNT-1:0]   mask_q;
  logic [OFF_W-1:0]       off_q;    // offset of the next transfer in a block
  logic                   sLat_q;

  logic [REG_COUNT-1:0]   src_mask;
  logic                   src_up;
  logic [IDX_W-1:0]       pick_idx;
  logic [REG_COUNT-1:0]   rem_mask;
  logic [3:0]             alu_dec;

  // In IDLE the first pick comes straight from the incoming list; in XFER
  // it comes from the latched remainder.
  assign src_mask = (state_q == XFER) ? mask_q : regList;
  assign src_up   = (state_q == XFER) ? xferUp : upDir;

  // Priority pick: lowest set bit when ascending, highest when descending.
  always_comb begin
    pick_idx = '0;
    if (src_up) begin
      for (int i = REG_COUNT-1; i >= 0; i--)
        if (src_mask[i]) pick_idx = IDX_W'(i);
    end else begin
      for (int i = 0; i < REG_COUNT; i++)
        if (src_mask[i]) pick_idx = IDX_W'(i);
    end
  end

  assign rem_mask = src_mask & ~({{(REG_COUNT-1){1'b0}}, 1'b1} << pick_idx);

  // ALU command decode for data-processing opcodes.
  always_comb begin
    case (opcode)
      4'b1101: alu_dec = 4'b0001;
      4'b1111: alu_dec = 4'b1001;
      4'b0100: alu_dec = 4'b0010;
      4'b0101: alu_dec = 4'b0011;
      4'b0010: alu_dec = 4'b0100;
      4'b0110: alu_dec = 4'b0101;
      4'b0000: alu_dec = 4'b0110;
      4'b1100: alu_dec = 4'b0111;
      4'b0001: alu_dec = 4'b1000;
      4'b1010: alu_dec = 4'b0100;
      4'b1000: alu_dec = 4'b0110;
      default: alu_dec = 4'b0001;
    endcase
  end

  // Control FSM: flush clears, freeze holds, otherwise decode or sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;   mask_q <= '0;    off_q <= '0;     sLat_q <= 1'b0;
      aluCmd  <= '0;     memRead <= 1'b0; memWrite <= 1'b0; wbEn <= 1'b0;
      branch  <= 1'b0;   sOut <= 1'b0;    ctrlValid <= 1'b0;
      xferReg <= '0;     xferOff <= '0;   xferUp <= 1'b0;
      lastXfer <= 1'b0;  busy <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;   mask_q <= '0;    off_q <= '0;     sLat_q <= 1'b0;
      aluCmd  <= '0;     memRead <= 1'b0; memWrite <= 1'b0; wbEn <= 1'b0;
      branch  <= 1'b0;   sOut <= 1'b0;    ctrlValid <= 1'b0;
      xferReg <= '0;     xferOff <= '0;   xferUp <= 1'b0;
      lastXfer <= 1'b0;  busy <= 1'b0;
    end else if (!freeze) begin
      memRead <= 1'b0; memWrite <= 1'b0; wbEn <= 1'b0; branch <= 1'b0;
      sOut <= 1'b0; ctrlValid <= 1'b0; lastXfer <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instValid) begin
            xferReg <= '0;
            xferOff <= '0;
            case (mode)
              2'b00: begin
                aluCmd    <= alu_dec;
                sOut      <= sIn;
                wbEn      <= !(opcode == 4'b1010 || opcode == 4'b1000 || opcode == 4'b0011);
                ctrlValid <= 1'b1;
                lastXfer  <= 1'b1;
              end
              2'b01: begin
                aluCmd    <= 4'b0010;
                wbEn      <= sIn;
                memRead   <= sIn;
                memWrite  <= !sIn;
                ctrlValid <= 1'b1;
                lastXfer  <= 1'b1;
              end
              2'b10: begin
                aluCmd    <= alu_dec;
                branch    <= 1'b1;
                ctrlValid <= 1'b1;
                lastXfer  <= 1'b1;
              end
              default: begin
                aluCmd <= 4'b0010;
                // An empty list is a no-op: nothing latched, nothing emitted.
                if (regList != '0) begin
                  xferUp    <= upDir;
                  sLat_q    <= sIn;
                  xferReg   <= pick_idx;
                  memRead   <= sIn;
                  wbEn      <= sIn;
                  memWrite  <= !sIn;
                  ctrlValid <= 1'b1;
                  mask_q    <= rem_mask;
                  off_q     <= OFF_W'(ADDR_STEP);
                  lastXfer  <= (rem_mask == '0);
                  busy      <= (rem_mask != '0);
                  state_q   <= (rem_mask != '0) ? XFER : IDLE;
                end
              end
            endcase
          end
        end
        XFER: begin
          xferReg   <= pick_idx;
          xferOff   <= off_q;
          memRead   <= sLat_q;
          wbEn      <= sLat_q;
          memWrite  <= !sLat_q;
          ctrlValid <= 1'b1;
          mask_q    <= rem_mask;
          if (rem_mask == '0) begin
            lastXfer <= 1'b1;
            busy     <= 1'b0;
            off_q    <= '0;
            state_q  <= IDLE;
          end else begin
            off_q    <= off_q + OFF_W'(ADDR_STEP);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_xfer_ctrl.sv
// Directed bench for block_xfer_ctrl: a vector table for single-cycle
// instructions plus hand sequences for block transfers, freeze, flush, reset.
module tb_block_xfer_ctrl;

  logic        clk, rst, instValid, sIn, upDir, freeze, flush;
  logic [1:0]  mode;
  logic [3:0]  opcode;
  logic [15:0] regList;
  logic [3:0]  aluCmd;
  logic        memRead, memWrite, wbEn, branch, sOut, ctrlValid, xferUp, lastXfer, busy;
  logic [3:0]  xferReg;
  logic [6:0]  xferOff;

  block_xfer_ctrl dut (
    .clk(clk), .rst(rst), .instValid(instValid), .mode(mode), .opcode(opcode),
    .sIn(sIn), .regList(regList), .upDir(upDir), .freeze(freeze), .flush(flush),
    .aluCmd(aluCmd), .memRead(memRead), .memWrite(memWrite), .wbEn(wbEn),
    .branch(branch), .sOut(sOut), .ctrlValid(ctrlValid), .xferReg(xferReg),
    .xferOff(xferOff), .xferUp(xferUp), .lastXfer(lastXfer), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu;
    logic mr, mw, wb, br, so, cv, lx, bz, xu;
    logic [3:0] xr;
    logic [6:0] xo;
  } out_t;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] opc;
    logic       s;
    out_t       exp;
  } vec_t;

  int checks = 0;
  int failures = 0;

  function automatic out_t mk(int alu, int mr, int mw, int wb, int br, int so,
                              int cv, int lx, int bz, int xr, int xo, int xu);
    out_t o;
    o.alu = 4'(alu); o.mr = 1'(mr); o.mw = 1'(mw); o.wb = 1'(wb); o.br = 1'(br);
    o.so = 1'(so); o.cv = 1'(cv); o.lx = 1'(lx); o.bz = 1'(bz);
    o.xr = 4'(xr); o.xo = 7'(xo); o.xu = 1'(xu);
    return o;
  endfunction

  function automatic out_t cur();
    out_t o;
    o.alu = aluCmd; o.mr = memRead; o.mw = memWrite; o.wb = wbEn; o.br = branch;
    o.so = sOut; o.cv = ctrlValid; o.lx = lastXfer; o.bz = busy;
    o.xr = xferReg; o.xo = xferOff; o.xu = xferUp;
    return o;
  endfunction

  task automatic chk(input string name, input out_t exp);
    out_t act;
    act = cur();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Block transfer with expectations derived from a simple bit-order model.
  task automatic run_block(input string name, input logic [15:0] m,
                           input logic up, input logic s);
    int idx[$];
    int n;
    if (up) begin
      for (int i = 0; i < 16; i++) if (m[i]) idx.push_back(i);
    end else begin
      for (int i = 15; i >= 0; i--) if (m[i]) idx.push_back(i);
    end
    n = idx.size();
    mode = 2'b11; opcode = 4'b0000; regList = m; upDir = up; sIn = s; instValid = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      instValid = 1'b0;
      chk($sformatf("%s_x%0d", name, k),
          mk(2, s, !s, s, 0, 0, 1, k == n-1, k != n-1, idx[k], k*4, up));
    end
    step();
    chk({name, "_idle"}, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, idx[n-1], (n-1)*4, up));
  endtask

  vec_t vt[15];

  initial begin
    vt[0]  = '{2'b00, 4'b1010, 1'b1, mk(4'b0100, 0,0,0,0,1, 1,1,0, 0,0,0)};
    vt[1]  = '{2'b00, 4'b1101, 1'b0, mk(4'b0001, 0,0,1,0,0, 1,1,0, 0,0,0)};
    vt[2]  = '{2'b00, 4'b1111, 1'b1, mk(4'b1001, 0,0,1,0,1, 1,1,0, 0,0,0)};
    vt[3]  = '{2'b00, 4'b0100, 1'b0, mk(4'b0010, 0,0,1,0,0, 1,1,0, 0,0,0)};
    vt[4]  = '{2'b00, 4'b0011, 1'b0, mk(4'b0001, 0,0,0,0,0, 1,1,0, 0,0,0)};
    vt[5]  = '{2'b00, 4'b1000, 1'b0, mk(4'b0110, 0,0,0,0,0, 1,1,0, 0,0,0)};
    vt[6]  = '{2'b00, 4'b0001, 1'b1, mk(4'b1000, 0,0,1,0,1, 1,1,0, 0,0,0)};
    vt[7]  = '{2'b00, 4'b0111, 1'b0, mk(4'b0001, 0,0,1,0,0, 1,1,0, 0,0,0)};
    vt[8]  = '{2'b00, 4'b0010, 1'b0, mk(4'b0100, 0,0,1,0,0, 1,1,0, 0,0,0)};
    vt[9]  = '{2'b00, 4'b0110, 1'b0, mk(4'b0101, 0,0,1,0,0, 1,1,0, 0,0,0)};
    vt[10] = '{2'b00, 4'b0000, 1'b0, mk(4'b0110, 0,0,1,0,0, 1,1,0, 0,0,0)};
    vt[11] = '{2'b00, 4'b1100, 1'b0, mk(4'b0111, 0,0,1,0,0, 1,1,0, 0,0,0)};
    vt[12] = '{2'b01, 4'b1101, 1'b1, mk(4'b0010, 1,0,1,0,0, 1,1,0, 0,0,0)};
    vt[13] = '{2'b01, 4'b0000, 1'b0, mk(4'b0010, 0,1,0,0,0, 1,1,0, 0,0,0)};
    vt[14] = '{2'b10, 4'b0101, 1'b1, mk(4'b0011, 0,0,0,1,0, 1,1,0, 0,0,0)};

    rst = 1'b0; instValid = 1'b0; mode = 2'b00; opcode = 4'b0000; sIn = 1'b0;
    regList = 16'h0; upDir = 1'b0; freeze = 1'b0; flush = 1'b0;
    #12;
    chk("reset", mk(0,0,0,0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    rst = 1'b1;
    step();

    // Single-cycle instruction table.
    for (int i = 0; i < 15; i++) begin
      mode = vt[i].mode; opcode = vt[i].opc; sIn = vt[i].s; instValid = 1'b1;
      step();
      chk($sformatf("vec%0d", i), vt[i].exp);
    end
    instValid = 1'b0;
    step();
    chk("no_accept", mk(4'b0011, 0,0,0,0,0, 0,0,0, 0,0,0));

    // Empty list is a no-op.
    mode = 2'b11; regList = 16'h0; upDir = 1'b1; sIn = 1'b1; instValid = 1'b1;
    step();
    instValid = 1'b0;
    chk("empty_list", mk(4'b0010, 0,0,0,0,0, 0,0,0, 0,0,0));

    run_block("b8091", 16'h8091, 1'b1, 1'b1);
    run_block("b0006", 16'h0006, 1'b0, 1'b0);
    run_block("b0001", 16'h0001, 1'b1, 1'b1);
    run_block("b8000", 16'h8000, 1'b0, 1'b0);
    run_block("bA5A5", 16'hA5A5, 1'b0, 1'b1);
    run_block("bFFFF", 16'hFFFF, 1'b1, 1'b0);

    // Hand-written check of the 0x8091 ordering and offsets.
    mode = 2'b11; regList = 16'h8091; upDir = 1'b1; sIn = 1'b1; instValid = 1'b1;
    step(); instValid = 1'b0; chk("h8091_0", mk(2, 1,0,1,0,0, 1,0,1,  0, 0,1));
    step();                   chk("h8091_1", mk(2, 1,0,1,0,0, 1,0,1,  4, 4,1));
    step();                   chk("h8091_2", mk(2, 1,0,1,0,0, 1,0,1,  7, 8,1));
    step();                   chk("h8091_3", mk(2, 1,0,1,0,0, 1,1,0, 15,12,1));
    step();

    // Freeze for two edges after the first transfer of 0x00F0.
    regList = 16'h00F0; upDir = 1'b1; sIn = 1'b1; instValid = 1'b1;
    step(); instValid = 1'b0; chk("frz_first", mk(2, 1,0,1,0,0, 1,0,1, 4, 0,1));
    freeze = 1'b1;
    step();                   chk("frz_hold1", mk(2, 1,0,1,0,0, 1,0,1, 4, 0,1));
    step();                   chk("frz_hold2", mk(2, 1,0,1,0,0, 1,0,1, 4, 0,1));
    freeze = 1'b0;
    step();                   chk("frz_r5", mk(2, 1,0,1,0,0, 1,0,1, 5, 4,1));
    step();                   chk("frz_r6", mk(2, 1,0,1,0,0, 1,0,1, 6, 8,1));
    step();                   chk("frz_r7", mk(2, 1,0,1,0,0, 1,1,0, 7,12,1));
    step();

    // Flush during the second transfer of four, together with freeze.
    regList = 16'h000F; upDir = 1'b1; sIn = 1'b0; instValid = 1'b1;
    step(); instValid = 1'b0; chk("fl_first", mk(2, 0,1,0,0,0, 1,0,1, 0, 0,1));
    flush = 1'b1; freeze = 1'b1;
    step();                   chk("fl_clear", mk(0,0,0,0,0,0,0,0,0,0,0,0));
    flush = 1'b0; freeze = 1'b0;
    mode = 2'b00; opcode = 4'b1101; sIn = 1'b0; instValid = 1'b1;
    step();                   chk("fl_next", mk(4'b0001, 0,0,1,0,0, 1,1,0, 0,0,0));
    instValid = 1'b0;

    // Asynchronous reset mid-transfer.
    mode = 2'b11; regList = 16'h000F; upDir = 1'b0; sIn = 1'b1; instValid = 1'b1;
    step(); instValid = 1'b0; chk("rs_first", mk(2, 1,0,1,0,0, 1,0,1, 3, 0,0));
    #2 rst = 1'b0;
    #1 chk("rs_async", mk(0,0,0,0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    rst = 1'b1;
    mode = 2'b10; opcode = 4'b0101; instValid = 1'b1;
    step();                   chk("rs_next", mk(4'b0011, 0,0,0,1,0, 1,1,0, 0,0,0));
    instValid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
